wb_burst_dp_ram: RTL
====================

# wb_burst_dp_ram

Single-clock, dual-port Wishbone RAM with registered-feedback burst support: both ports accept classic cycles and CTI/BTE incrementing and wrapping bursts, sustaining one beat per clock after a one-cycle initial latency. Memory depth is a power-of-two parameter independent of the bus address width. Sits beside the existing dual-port RAM as the shared buffer between burst-capable masters (DMA, cache refill) in the same clock domain.

## Interface
- DATA_WIDTH, 32: data bus width (8/16/32/64).
- ADDR_WIDTH, 16: byte address width.
- SELECT_WIDTH, DATA_WIDTH/8: byte-select width.
- DEPTH, 2**(ADDR_WIDTH-$clog2(SELECT_WIDTH)): words; power of two, ≤ word address space.
- INIT_FILE, "": hex image loaded with $readmemh when non-empty.
- clk  in  1  single clock for both ports.
- rst  in  1  reset; asynchronous, active-high.
- a_adr_i / b_adr_i  in  ADDR_WIDTH  byte address; low $clog2(SELECT_WIDTH) bits ignored.
- a_dat_i / b_dat_i  in  DATA_WIDTH  write data.
- a_dat_o / b_dat_o  out  DATA_WIDTH  read data.
- a_we_i / b_we_i  in  1  write enable.
- a_sel_i / b_sel_i  in  SELECT_WIDTH  byte lane enables (writes only).
- a_stb_i / b_stb_i, a_cyc_i / b_cyc_i  in  1  strobe, cycle.
- a_cti_i / b_cti_i  in  3  cycle type: 000 classic, 001 constant (treated classic), 010 incrementing, 111 end of burst.
- a_bte_i / b_bte_i  in  2  00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- a_ack_o / b_ack_o, a_err_o / b_err_o  out  1  acknowledge, error.

## Operation
- Ports are identical and independent; per-port FSM IDLE, SINGLE, BURST, ERR. Word index = adr >> $clog2(SELECT_WIDTH); cur = word whose data is on dat_o.
- IDLE, edge with cyc&stb: write lanes per sel if we; dat_o <= old mem[index] (read-first); ack <= 1; cur <= index. cti==010 → BURST, else → SINGLE.
- SINGLE: ack high one cycle; next edge ack <= 0 → IDLE; request ignored on that edge.
- BURST (ack high): edge with cyc&stb&index==cur terminates the beat. If cti==111 → ack <= 0, IDLE. Else cur <= next(cur), dat_o <= mem[next(cur)], ack stays 1. Writes: presented beat written at its terminating edge except the first BURST edge (beat 0 already written in IDLE).
- next(): linear = cur+1 modulo DEPTH; wrap-N = low log2(N) bits incremented modulo N, upper bits held.
- BURST abort: stb low, cyc low, or index≠cur → ack <= 0, IDLE, no write; prefetched data discarded; a still-present request restarts from IDLE next edge.
- Cross-port: same-edge writes to same word, overlapping lanes → port A wins; non-overlapping lanes both land. Read concurrent with other port's write returns old data.

## Timing
- Reset (async): all ack_o/err_o = 0, dat_o = 0, FSMs IDLE; memory contents retained.
- Classic: ack 1 cycle after stb, one cycle wide; max one transfer per 2 cycles.
- Burst of N beats: first ack 1 cycle after stb, then one beat per cycle; N+1 cycles total, ack continuous.
- dat_o updated only on accepted/prefetch edges; otherwise holds.
- Reset asserted mid-burst: ack drops immediately (asynchronously); partially written burst beats remain.

## Configuration
- WB_BURST_RAM_ERR_EN defined: a word index ≥ DEPTH (address bits above $clog2(DEPTH) nonzero) in IDLE → no write, dat_o held, err <= 1 for one cycle (state ERR) instead of ack, then IDLE. In BURST, linear next(cur) reaching DEPTH → ack <= 0, err <= 1 for the following beat, ERR → IDLE.
- Undefined: upper address bits ignored (aliasing), linear bursts wrap DEPTH-1 → 0, err_o tied 0.

## Test plan
- Reset, classic write a_adr=0x10 data 0xDEADBEEF sel 1111, then read → ack 1 cycle after stb each; read returns 0xDEADBEEF; dat_o=0 after reset.
- Port A 4-beat linear read burst from word 2 (cti 010,010,010,111) over preloaded words 2..5 = 1,2,3,4 → acks on 4 consecutive cycles starting 1 cycle after stb, data 1,2,3,4, ack low after.
- Port B wrap-4 write burst from word 6 with data A,B,C,D → words 6,7,4,5 = A,B,C,D; word 8 unchanged.
- Same edge: A writes word 3 sel 0011 data 0x11111111, B writes word 3 sel 0110 data 0x22222222 → word 3 lanes = 0x??221111 with lane 1 from A; B read of word 3 same edge returns old value.
- Burst with stb dropped after beat 2 of 8, then address jump → ack falls next edge, no write of un-terminated beats, new request served as fresh classic cycle.
- ERR_EN, DEPTH=16: read word 16 → err 1 cycle, no ack; linear burst from word 14 → acks for 14,15, err on third beat. Without macro: word 16 aliases word 0.

Source files
------------

// File: rtl/wb_burst_dp_ram_if.sv
// Wishbone registered-feedback slave bundle for one port of wb_burst_dp_ram.
// Signal names keep the classic _i/_o suffixes as seen from the RAM (slave).
//   adr_i  byte address           dat_i  write data      dat_o  read data
//   we_i   write enable           sel_i  byte lanes      stb_i/cyc_i strobe/cycle
//   cti_i  cycle type             bte_i  burst type      ack_o/err_o acknowledge/error
interface wb_burst_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0]   adr_i;
  logic [DATA_WIDTH-1:0]   dat_i;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic                    we_i;
  logic [SELECT_WIDTH-1:0] sel_i;
  logic                    stb_i;
  logic                    cyc_i;
  logic [2:0]              cti_i;
  logic [1:0]              bte_i;
  logic                    ack_o;
  logic                    err_o;

  modport master (
    output adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, cti_i, bte_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, cti_i, bte_i,
    output dat_o, ack_o, err_o
  );
endinterface

// File: rtl/wb_burst_dp_ram.sv
// wb_burst_dp_ram: single-clock dual-port Wishbone RAM with CTI/BTE burst
// support (classic, incrementing, wrap-4/8/16), one beat per clock after a
// one-cycle initial latency. Read-first on both ports; on same-word same-lane
// writes port A wins.
// Ports:
//   clk  single clock for both ports
//   rst  asynchronous active-high reset (clears ack/err/dat_o, not memory)
//   a, b wb_burst_if.slave bundles (adr/dat/we/sel/stb/cyc/cti/bte, dat/ack/err)
// Optional feature: define WB_BURST_RAM_ERR_EN to flag out-of-range word
// indices (and linear bursts running past DEPTH-1) with err_o instead of
// aliasing/wrapping.

// Per-port transfer control: decides what gets written and what gets
// prefetched onto dat_o on each edge.
module wb_burst_port_fsm #(
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = 4,
  parameter int DEPTH        = 16384
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        adr,
  input  logic                         we,
  input  logic                         stb,
  input  logic                         cyc,
  input  logic [2:0]                   cti,
  input  logic [1:0]                   bte,
  output logic                         ack,
  output logic                         err,
  output logic                         wr_en,
  output logic [$clog2(DEPTH)-1:0]     wr_idx,
  output logic                         rd_en,
  output logic [$clog2(DEPTH)-1:0]     rd_idx
);
  localparam int OFF = $clog2(SELECT_WIDTH);
  localparam int IW  = $clog2(DEPTH);
  localparam int WAW = ADDR_WIDTH - OFF;

  typedef enum logic [1:0] {IDLE, SINGLE, BURST, ERR} state_t;

  state_t          state, state_n;
  logic            ack_n, err_n;
  logic [IW-1:0]   cur, cur_n;
  logic            first, first_n;
  logic [WAW-1:0]  wadr;
  logic [IW-1:0]   index;
  logic [IW-1:0]   mask, inc, nxt;
  logic            req, hit;
  logic            unused_bits;

  assign wadr        = adr[ADDR_WIDTH-1:OFF];
  assign index       = wadr[IW-1:0];
  assign req         = cyc & stb;
  assign unused_bits = ^adr;

`ifdef WB_BURST_RAM_ERR_EN
  logic oor;
  if (WAW > IW) begin : g_oor
    assign oor = |wadr[WAW-1:IW];
  end else begin : g_no_oor
    assign oor = 1'b0;
  end
  assign hit = (index == cur) && !oor;
`else
  assign hit = (index == cur);
`endif

  // Wrapping bursts only advance the low log2(N) bits; linear uses all bits
  // so the index rolls over modulo DEPTH.
  always_comb begin
    unique case (bte)
      2'b00:   mask = '1;
      2'b01:   mask = IW'(3);
      2'b10:   mask = IW'(7);
      default: mask = IW'(15);
    endcase
    inc = cur + 1'b1;
    nxt = (cur & ~mask) | (inc & mask);
  end

  assign wr_idx = index;

  always_comb begin
    state_n = state;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    cur_n   = cur;
    first_n = first;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    rd_idx  = index;
    case (state)
      IDLE: begin
        if (req) begin
`ifdef WB_BURST_RAM_ERR_EN
          if (oor) begin
            err_n   = 1'b1;
            state_n = ERR;
          end else
`endif
          begin
            wr_en   = we;
            rd_en   = 1'b1;
            ack_n   = 1'b1;
            cur_n   = index;
            first_n = 1'b1;
            state_n = (cti == 3'b010) ? BURST : SINGLE;
          end
        end
      end
      SINGLE: state_n = IDLE;
      BURST: begin
        if (req && hit) begin
          // Beat 0 was already written on the accepting edge in IDLE.
          wr_en   = we && !first;
          first_n = 1'b0;
          if (cti == 3'b111) begin
            state_n = IDLE;
          end
`ifdef WB_BURST_RAM_ERR_EN
          else if (bte == 2'b00 && cur == IW'(DEPTH - 1)) begin
            err_n   = 1'b1;
            state_n = ERR;
          end
`endif
          else begin
            ack_n  = 1'b1;
            cur_n  = nxt;
            rd_en  = 1'b1;
            rd_idx = nxt;
          end
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ack   <= 1'b0;
      err   <= 1'b0;
      cur   <= '0;
      first <= 1'b0;
    end else begin
      state <= state_n;
      ack   <= ack_n;
      err   <= err_n;
      cur   <= cur_n;
      first <= first_n;
    end
  end
endmodule

module wb_burst_dp_ram #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH        = 2 ** (ADDR_WIDTH - $clog2(SELECT_WIDTH)),
  parameter     INIT_FILE    = ""
) (
  input logic      clk,
  input logic      rst,
  wb_burst_if.slave a,
  wb_burst_if.slave b
);
  localparam int IW   = $clog2(DEPTH);
  localparam int LANE = DATA_WIDTH / SELECT_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          a_wr, a_rd, b_wr, b_rd;
  logic [IW-1:0] a_wr_idx, a_rd_idx, b_wr_idx, b_rd_idx;

  wb_burst_port_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH), .SELECT_WIDTH(SELECT_WIDTH), .DEPTH(DEPTH)
  ) u_port_a (
    .clk(clk), .rst(rst),
    .adr(a.adr_i), .we(a.we_i), .stb(a.stb_i), .cyc(a.cyc_i),
    .cti(a.cti_i), .bte(a.bte_i),
    .ack(a.ack_o), .err(a.err_o),
    .wr_en(a_wr), .wr_idx(a_wr_idx), .rd_en(a_rd), .rd_idx(a_rd_idx)
  );

  wb_burst_port_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH), .SELECT_WIDTH(SELECT_WIDTH), .DEPTH(DEPTH)
  ) u_port_b (
    .clk(clk), .rst(rst),
    .adr(b.adr_i), .we(b.we_i), .stb(b.stb_i), .cyc(b.cyc_i),
    .cti(b.cti_i), .bte(b.bte_i),
    .ack(b.ack_o), .err(b.err_o),
    .wr_en(b_wr), .wr_idx(b_wr_idx), .rd_en(b_rd), .rd_idx(b_rd_idx)
  );

  // Port A's lane assignment comes last so it overrides B on overlapping
  // lanes of the same word; disjoint lanes from both ports both land.
  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < SELECT_WIDTH; l++) begin
      if (b_wr && b.sel_i[l]) mem[b_wr_idx][l*LANE +: LANE] <= b.dat_i[l*LANE +: LANE];
      if (a_wr && a.sel_i[l]) mem[a_wr_idx][l*LANE +: LANE] <= a.dat_i[l*LANE +: LANE];
    end
  end

  // Read-first: both reads see the memory contents before this edge's writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a.dat_o <= '0;
      b.dat_o <= '0;
    end else begin
      if (a_rd) a.dat_o <= mem[a_rd_idx];
      if (b_rd) b.dat_o <= mem[b_rd_idx];
    end
  end
endmodule
